// File: rtl/kb_typematic_fifo_pkg.sv
// Shared constants for the keyboard typematic front-end: FSM encodings,
// ASCII field position and default typematic timings at 50 MHz.
package kb_typematic_fifo_pkg;

    typedef enum logic [1:0] {
        KB_IDLE   = 2'd0,
        KB_DELAY  = 2'd1,
        KB_REPEAT = 2'd2
    } kb_state_t;

    localparam int KB_ASCII_LSB = 0;
    localparam int KB_ASCII_MSB = 7;

    // Clock counts for CLOCK_50
    localparam int MS500 = 25_000_000;
    localparam int MS250 = 12_500_000;
    localparam int MS50  = 2_500_000;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. Head entry is visible on dout without a pop;
// a push into a full FIFO without a concurrent pop is dropped and flagged.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              drop
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A pop frees a slot in the same edge, so push into a full FIFO is legal then
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kb_typematic_fifo.sv
// Keyboard event front-end: registers the kb_driver key code, turns it into
// press/auto-repeat events and queues them for the CPU with overflow and irq.
module kb_typematic_fifo
    import kb_typematic_fifo_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 16,
    parameter int DELAY_CYC  = MS500,
    parameter int REPEAT_CYC = MS50,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] key_data,
    input  logic              repeat_en,
    input  logic              irq_en,
    input  logic              pop,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              irq,
    output kb_state_t         dbg_state
);

    localparam int MAX_CYC = (DELAY_CYC > REPEAT_CYC) ? DELAY_CYC : REPEAT_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(DELAY_CYC - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYC - 1);

    kb_state_t         state;
    kb_state_t         state_nxt;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_nxt;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] held_q;
    logic              key_nz;
    logic              push;
    logic              drop;

    assign key_nz = |key_q[KB_ASCII_MSB:KB_ASCII_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= '0;
            held_q <= '0;
            state  <= KB_IDLE;
            timer  <= '0;
        end else begin
            key_q <= key_data;
            state <= state_nxt;
            timer <= timer_nxt;
            if (push) begin
                held_q <= key_q;
            end
        end
    end

    // A saturated DELAY timer with repeat disabled waits for repeat_en to return
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        push      = 1'b0;
        case (state)
            KB_IDLE: begin
                timer_nxt = '0;
                if (key_nz) begin
                    push      = 1'b1;
                    state_nxt = KB_DELAY;
                end
            end
            KB_DELAY, KB_REPEAT: begin
                if (!key_nz) begin
                    state_nxt = KB_IDLE;
                    timer_nxt = '0;
                end else if (key_q != held_q) begin
                    push      = 1'b1;
                    state_nxt = KB_DELAY;
                    timer_nxt = '0;
                end else if (state == KB_DELAY && timer == DELAY_LAST) begin
                    if (repeat_en) begin
                        push      = 1'b1;
                        state_nxt = KB_REPEAT;
                        timer_nxt = '0;
                    end
                end else if (state == KB_REPEAT && timer == REPEAT_LAST) begin
                    if (repeat_en) begin
                        push      = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        state_nxt = KB_DELAY;
                        timer_nxt = DELAY_LAST;
                    end
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            default: begin
                state_nxt = KB_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (key_q),
        .dout  (rd_data),
        .empty (empty),
        .full  (full),
        .count (count),
        .drop  (drop)
    );

    // Set wins over a same-cycle clear so no drop goes unreported
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign irq       = irq_en && !empty;
    assign dbg_state = state;

endmodule
